// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY RX lane receiver: lane states, the default
// comma symbol and a counter-width helper.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

    localparam logic [7:0] DEF_COMMA = 8'hBC;

    // Width of a counter holding values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phy_rx_lane_align.sv
// Single serial lane: shifts in one bit per enabled clk (MSB first), finds word
// alignment from a comma, locks after ACTIVE_CNT aligned commas, then emits
// non-comma words with a one-cycle valid strobe.
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               ACTIVE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             d_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int BW = cnt_w(WIDTH);
    localparam int CW = cnt_w(ACTIVE_CNT + 1);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    lane_state_t      state_q, state_d;
    logic [WIDTH-2:0] sr_q;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             active_q;
    logic [WIDTH-1:0] window;
    logic             is_comma;
    logic             boundary;

    // The word as it would look if this edge closed it.
    assign window   = {sr_q, d_in};
    assign is_comma = (window == COMMA);
    assign boundary = (bit_cnt_q == LAST);

    // Next-state and datapath decisions for one enabled edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        case (state_q)
            SEARCH: begin
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = CW'(1);
                    state_d     = (ACTIVE_CNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        if (comma_cnt_q != '1)
                            comma_cnt_d = comma_cnt_q + 1'b1;
                        if (int'(comma_cnt_q) + 1 == ACTIVE_CNT)
                            state_d = ACTIVE;
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Commas are idle fill; only real words are delivered.
                if (boundary && !is_comma) begin
                    data_d  = window;
                    valid_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Lane state; everything freezes while disabled except the valid strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            sr_q        <= window[WIDTH-2:0];
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= (state_d == ACTIVE);
        end else begin
            valid_q     <= 1'b0;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: rtl/phy_rx_lanes.sv
// Multi-lane PHY RX front end: LANES independent aligners side by side, plus a
// summary flag that every lane is locked.
module phy_rx_lanes
    import phy_rx_pkg::*;
#(
    parameter int               LANES      = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               ACTIVE_CNT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [LANES-1:0]       d_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic [LANES-1:0]       active,
    output logic                   all_active
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_rx_lane_align #(
            .WIDTH      (WIDTH),
            .COMMA      (COMMA),
            .ACTIVE_CNT (ACTIVE_CNT)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .d_in      (d_in[i]),
            .data_out  (data_out[i*WIDTH +: WIDTH]),
            .valid_out (valid_out[i]),
            .active    (active[i])
        );
    end

    assign all_active = &active;

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Bench for phy_rx_lanes: bit-stream stimulus, a stream-position reference
// model feeding per-lane expected-word queues, and a negedge monitor.
module tb_phy_rx_lanes;

    localparam int LANES = 2;
    localparam int ACTIVE_CNT = 4;
    localparam int COMMA = 8'hBC;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic [LANES-1:0] d_in = '0;
    logic [15:0]      data_out;
    logic [LANES-1:0] valid_out;
    logic [LANES-1:0] active;
    logic             all_active;

    phy_rx_lanes #(.LANES(LANES), .WIDTH(8), .COMMA(8'hBC), .ACTIVE_CNT(ACTIVE_CNT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .d_in(d_in),
        .data_out(data_out), .valid_out(valid_out), .active(active), .all_active(all_active)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: position of each bit in the lane stream since reset.
    int win [LANES];
    int pos [LANES];
    int anchor [LANES];
    int ncom [LANES];
    bit lk [LANES];

    logic [7:0] exp0[$], exp1[$];
    logic       in0[$], in1[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            win[i] = 0; pos[i] = 0; anchor[i] = -1; ncom[i] = 0; lk[i] = 1'b0;
        end
        exp0.delete(); exp1.delete();
    endtask

    // A lane locks once ACTIVE_CNT commas sit at 8-bit stride; after that every
    // 8th bit closes a word and non-comma words are expected out.
    task automatic model_bit(input int i, input logic b);
        win[i] = ((win[i] << 1) | int'(b)) & 8'hFF;
        pos[i]++;
        if (lk[i]) begin
            if ((pos[i] - anchor[i]) % 8 == 0 && win[i] != COMMA) begin
                if (i == 0) exp0.push_back(8'(win[i])); else exp1.push_back(8'(win[i]));
            end
        end else if (anchor[i] < 0) begin
            if (win[i] == COMMA) begin
                anchor[i] = pos[i]; ncom[i] = 1;
                if (ncom[i] >= ACTIVE_CNT) lk[i] = 1'b1;
            end
        end else if ((pos[i] - anchor[i]) % 8 == 0) begin
            if (win[i] == COMMA) begin
                ncom[i]++;
                if (ncom[i] == ACTIVE_CNT) lk[i] = 1'b1;
            end else begin
                anchor[i] = -1; ncom[i] = 0;
            end
        end
    endtask

    task automatic step(input logic [LANES-1:0] b, input logic en);
        d_in = b; enable = en;
        @(posedge clk); #1;
        if (en) for (int i = 0; i < LANES; i++) model_bit(i, b[i]);
    endtask

    task automatic put_word(input int lane, input logic [7:0] w);
        for (int k = 7; k >= 0; k--) begin
            if (lane == 0) in0.push_back(w[k]); else in1.push_back(w[k]);
        end
    endtask

    task automatic put_bits(input int lane, input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic v;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (lane == 0) in0.push_back(v); else in1.push_back(v);
        end
    endtask

    // Feed up to n bits per lane (idle lanes get 0); optional random stalls.
    task automatic run_n(input int n, input bit rnd_en);
        for (int k = 0; k < n && (in0.size() > 0 || in1.size() > 0); k++) begin
            logic [LANES-1:0] b;
            logic en;
            en = rnd_en ? ($urandom_range(0, 5) != 0) : 1'b1;
            if (en) begin
                b[0] = (in0.size() > 0) ? in0.pop_front() : 1'b0;
                b[1] = (in1.size() > 0) ? in1.pop_front() : 1'b0;
            end else begin
                b = 2'($urandom_range(0, 3));
            end
            step(b, en);
            if (!en) chk("valid_while_disabled", valid_out, 0);
        end
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        model_reset();
        in0.delete(); in1.delete();
        #1;
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_active", active, 0);
        chk("rst_all_active", all_active, 0);
        @(negedge clk); @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor: every valid must match the head of that lane's expected queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                int qs;
                qs = (i == 0) ? exp0.size() : exp1.size();
                if (valid_out[i]) begin
                    if (qs == 0) chk("unexpected_valid", 1, 0);
                    else chk("data_lane", data_out[i*8 +: 8], (i == 0) ? exp0.pop_front() : exp1.pop_front());
                end else if (qs != 0) begin
                    chk("missing_valid", 0, 1);
                    if (i == 0) exp0.delete(); else exp1.delete();
                end
                chk("active_lane", active[i], lk[i]);
            end
            chk("all_active", all_active, lk[0] & lk[1]);
        end
    end

    initial begin
        model_reset();
        #1;
        chk("init_valid", valid_out, 0);
        chk("init_active", active, 0);
        @(negedge clk); @(negedge clk);
        #1 reset = 1'b1;

        // Lock both lanes, then one data word each and an idle comma.
        for (int k = 0; k < 4; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        run_n(32, 1'b0);
        chk("lock_active", active, 2'b11);
        chk("lock_all_active", all_active, 1);
        put_word(0, 8'hA5); put_word(1, 8'h3C);
        put_word(0, 8'hBC); put_word(1, 8'hBC);
        run_n(16, 1'b0);
        chk("data_held_after_comma", data_out, 16'h3CA5);

        // Alignment at a 3-bit offset on lane 0.
        do_reset();
        put_bits(0, 3, 1'b1);
        for (int k = 0; k < 4; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        put_word(0, 8'h5A); put_word(1, 8'h5A);
        run_n(50, 1'b0);
        chk("offset_lane0_data", data_out[7:0], 8'h5A);
        chk("offset_lane1_data", data_out[15:8], 8'h5A);

        // Failed lock, then a good one.
        do_reset();
        for (int k = 0; k < 3; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        put_word(0, 8'h55); put_word(1, 8'h55);
        run_n(32, 1'b0);
        chk("failed_lock_active", active, 0);
        for (int k = 0; k < 4; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        put_word(0, 8'h77); put_word(1, 8'h81);
        run_n(40, 1'b0);
        chk("relock_active", active, 2'b11);
        chk("relock_data", data_out, 16'h8177);

        // Reset four bits into a data word; relock needs all four commas.
        put_word(0, 8'hC3); put_word(1, 8'h3C);
        run_n(4, 1'b0);
        do_reset();
        for (int k = 0; k < 3; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        put_word(0, 8'h12); put_word(1, 8'h34);
        run_n(32, 1'b0);
        chk("post_reset_3commas_active", active, 0);
        for (int k = 0; k < 4; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        put_word(0, 8'h12); put_word(1, 8'h34);
        run_n(40, 1'b0);
        chk("post_reset_relock_data", data_out, 16'h3412);

        // Lane 1 skewed by 5 bits; three stalled cycles mid-word.
        do_reset();
        put_bits(1, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin put_word(0, 8'hBC); put_word(1, 8'hBC); end
        for (int k = 0; k < 3; k++) begin
            put_word(0, 8'($urandom_range(0, 255)));
            put_word(1, 8'($urandom_range(0, 255)));
        end
        run_n(36, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'($urandom_range(0, 3)), 1'b0);
            chk("stall_valid", valid_out, 0);
        end
        run_n(40, 1'b0);

        // Randomized traffic: random skew, commas mixed into data, random stalls.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < LANES; i++) begin
                put_bits(i, $urandom_range(0, 7), 1'b0);
                for (int k = 0; k < 4; k++) put_word(i, 8'hBC);
                for (int k = 0; k < 20; k++)
                    put_word(i, ($urandom_range(0, 3) == 0) ? 8'hBC : 8'($urandom_range(0, 255)));
            end
            run_n(1000, 1'b1);
            step(2'b00, 1'b1);
        end

        @(negedge clk); #1;
        chk("exp0_drained", exp0.size(), 0);
        chk("exp1_drained", exp1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_rx_lanes.md
Name: phy_rx_lanes

Overview:
Parametrised multi-lane serial receiver for the PHY RX path. It replaces the fixed two-lane receiver. Each lane shifts in one bit per clk, MSB first, and finds word alignment from a comma symbol. After a run of consecutive aligned commas the lane declares itself active. From then on it delivers parallel data words with a one-cycle valid pulse and drops commas as idle. It sits between the serial lane inputs and the RX byte-unstriping logic.

Parameters:
LANES, 2, number of independent serial lanes
WIDTH, 8, bits per word (>=4)
COMMA, 8'hBC, alignment/idle symbol, WIDTH bits
ACTIVE_CNT, 4, consecutive aligned commas required to enter ACTIVE (>=1)

Ports:
clk  input  1  bit clock; one serial bit per lane per enabled rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = sample lanes; 0 = freeze all lane state
d_in  input  LANES  serial bit per lane, lane i = d_in[i]
data_out  output  LANES*WIDTH  lane i word at [i*WIDTH +: WIDTH]
valid_out  output  LANES  lane i one-cycle strobe, data_out slice valid
active  output  LANES  lane i aligned and passing data
all_active  output  1  AND of active[]

Behaviour:
- Reset (reset=0, asynchronous): every lane goes to SEARCH; sr, bit_cnt and comma_cnt clear; data_out=0, valid_out=0, active=0, all_active=0.
- Reset mid-word discards the partial word. Relock needs the full ACTIVE_CNT comma sequence again.
- Per lane: window = {sr[WIDTH-2:0], d_in[i]}. On each enabled edge, sr <= window.
- enable=0: sr, counters and state hold. valid_out forced 0. data_out and active hold.
- Lane states:
  - SEARCH: bit_cnt is ignored. When window==COMMA (at any bit offset): bit_cnt<=0, comma_cnt<=1. If ACTIVE_CNT==1, go to ACTIVE; otherwise go to ALIGN.
  - ALIGN: bit_cnt increments each enabled edge. A word boundary occurs at bit_cnt==WIDTH-1; bit_cnt then wraps to 0.
    - At a boundary, window==COMMA: comma_cnt++. If comma_cnt+1==ACTIVE_CNT, go to ACTIVE.
    - At a boundary, window!=COMMA: return to SEARCH, comma_cnt<=0.
    - A comma appearing in the window off a boundary is ignored.
  - ACTIVE: active=1 registered. At each boundary:
    - window!=COMMA: data_out slice <= window, valid_out[i]<=1 for exactly one cycle.
    - window==COMMA: idle, valid_out[i]=0, data_out holds.
    - ACTIVE is left only by reset. A comma never moves a lane out of ACTIVE.
- Latency: valid_out asserts on the clk edge that samples the last bit of the word. It is visible in the following cycle, i.e. the word is registered with no extra pipeline stage.
- active rises on the same edge as the ACTIVE_CNT-th comma boundary.
- all_active is combinational AND of the registered active bits.
- Lanes are fully independent. Skew between lanes of any number of bits is tolerated. valid_out bits of different lanes need not coincide.
- Simultaneous events: a boundary that completes the last required comma enters ACTIVE, and that comma produces no valid. The first valid can come from the next word.
- Widths: bit_cnt is $clog2(WIDTH) bits. comma_cnt is $clog2(ACTIVE_CNT+1) bits and saturates.

Decomposition:
- Shared package phy_rx_pkg: lane state enum (SEARCH, ALIGN, ACTIVE), default COMMA constant, and a clog2 helper for counter widths.
- One sub-module, phy_rx_lane_align: a single-lane shifter, counters and FSM with WIDTH, COMMA and ACTIVE_CNT parameters.
- The top instantiates LANES copies in a generate loop and forms all_active.

Test Plan:
- Lock: LANES=2, both lanes send 0xBC x4 MSB first from bit 0 -> active=2'b11 and all_active=1 after the 32nd bit edge; no valid_out during lock.
- Data: after lock, lane0 sends 0xA5 and lane1 sends 0x3C -> data_out=16'h3CA5, valid_out=2'b11 for exactly one cycle on the 8th bit edge; a following 0xBC gives valid_out=0 and data_out held.
- Offset align: lane0 sends 3 random bits then 0xBC x4 then 0x5A -> lane aligns at offset 3; data_out[7:0]=0x5A with one valid pulse.
- Failed lock: 0xBC x3 then 0x55 -> state returns to SEARCH, active=0, no valid. Then 0xBC x4 locks.
- Reset mid-operation: reset=0 at bit 4 of an active-data word -> all outputs 0 immediately (asynchronously). After release, the lane needs 4 commas before valid.
- Enable/skew: lane1 delayed 5 bits relative to lane0, and enable=0 for 3 cycles mid-word -> no bits lost, words and valids correct per lane, valid_out=0 while enable=0.
